// File: rtl/button_deb_multi.sv
// button_deb_multi: N-channel push-button debouncer sharing one 1 ms tick.
// Each channel yields a stable level plus press, release and long-press strobes.
module button_deb_multi #(
    parameter int CLK_FREQ        = 95_000,
    parameter int DEBOUNCE_PER_MS = 20,
    parameter int LONG_PRESS_MS   = 1000,
    parameter int N_CHAN          = 4,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CHAN-1:0] button_in,
    output logic [N_CHAN-1:0] button_valid,
    output logic [N_CHAN-1:0] button_press,
    output logic [N_CHAN-1:0] button_release,
    output logic [N_CHAN-1:0] button_long,
    output logic              tick_ms
);
    localparam int PW = $clog2(CLK_FREQ);
    localparam int DW = $clog2(DEBOUNCE_PER_MS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_PER_MS - 1);
    localparam logic [N_CHAN-1:0] IDLE = {N_CHAN{ACTIVE_LOW}};

    logic [PW-1:0]     pre_cnt;
    logic [N_CHAN-1:0] sync1;
    logic [N_CHAN-1:0] sync2;
    logic [N_CHAN-1:0] s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            tick_ms <= 1'b0;
        end else begin
            tick_ms <= (pre_cnt == P_LAST);
            pre_cnt <= (pre_cnt == P_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    // Synchroniser idles at the released pin level so reset never looks like a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ IDLE;

    for (genvar i = 0; i < N_CHAN; i++) begin : g_deb
        logic [DW-1:0] deb_cnt;
        logic          valid_q;
        logic          press_q;
        logic          rel_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                deb_cnt <= '0;
                valid_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (s[i] == valid_q) begin
                    deb_cnt <= '0;
                end else if (tick_ms) begin
                    if (deb_cnt == D_LAST) begin
                        deb_cnt <= '0;
                        valid_q <= s[i];
                        press_q <= s[i];
                        rel_q   <= !s[i];
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
            end
        end

        assign button_valid[i]   = valid_q;
        assign button_press[i]   = press_q;
        assign button_release[i] = rel_q;
    end

    if (LONG_PRESS_MS > 0) begin : g_long
        localparam int LW = $clog2(LONG_PRESS_MS + 1);
        localparam logic [LW-1:0] L_MAX = LW'(LONG_PRESS_MS);
        localparam logic [LW-1:0] L_PRE = LW'(LONG_PRESS_MS - 1);

        for (genvar i = 0; i < N_CHAN; i++) begin : g_ch
            logic [LW-1:0] hold_cnt;
            logic          long_q;

            // Saturates at L_MAX so the strobe fires once per press
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hold_cnt <= '0;
                    long_q   <= 1'b0;
                end else begin
                    long_q <= 1'b0;
                    if (!button_valid[i]) begin
                        hold_cnt <= '0;
                    end else if (tick_ms && hold_cnt != L_MAX) begin
                        hold_cnt <= hold_cnt + LW'(1);
                        long_q   <= (hold_cnt == L_PRE);
                    end
                end
            end

            assign button_long[i] = long_q;
        end
    end else begin : g_no_long
        assign button_long = '0;
    end

endmodule

// File: tb/tb_button_deb_multi.sv
// Bench for button_deb_multi: cycle model comparison on two polarities
// plus directed latency, bounce, long-press and reset scenarios.
module tb_button_deb_multi;
    localparam int F = 10;
    localparam int D = 3;
    localparam int L = 5;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] pins;
    logic [N-1:0] pins_al;

    logic [N-1:0] v0, p0, r0, l0;
    logic [N-1:0] v1, p1, r1, l1;
    logic         t0, t1;

    int checks = 0;
    int passes = 0;

    button_deb_multi #(
        .CLK_FREQ(F), .DEBOUNCE_PER_MS(D), .LONG_PRESS_MS(L),
        .N_CHAN(N), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .button_in(pins),
        .button_valid(v0), .button_press(p0), .button_release(r0),
        .button_long(l0), .tick_ms(t0)
    );

    button_deb_multi #(
        .CLK_FREQ(F), .DEBOUNCE_PER_MS(D), .LONG_PRESS_MS(L),
        .N_CHAN(N), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .button_in(pins_al),
        .button_valid(v1), .button_press(p1), .button_release(r1),
        .button_long(l1), .tick_ms(t1)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: state after each edge since reset release
    int           cyc;
    logic         m_tick;
    logic [N-1:0] m_valid[2], m_press[2], m_rel[2], m_long[2];
    logic [N-1:0] m_s1[2], m_s2[2];
    int           m_dis[2][N];
    int           m_held[2][N];

    function automatic logic [N-1:0] idle(input int k);
        return (k == 1) ? {N{1'b1}} : {N{1'b0}};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = '0;
                m_press[k] = '0;
                m_rel[k]   = '0;
                m_long[k]  = '0;
                m_s1[k]    = idle(k);
                m_s2[k]    = idle(k);
                for (int i = 0; i < N; i++) begin
                    m_dis[k][i]  = 0;
                    m_held[k][i] = 0;
                end
            end
            m_tick = 1'b0;
            cyc    = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) begin
                    logic s_old;
                    logic v_old;
                    s_old = m_s2[k][i] ^ (k == 1);
                    v_old = m_valid[k][i];
                    m_press[k][i] = 1'b0;
                    m_rel[k][i]   = 1'b0;
                    m_long[k][i]  = 1'b0;
                    if (!v_old) begin
                        m_held[k][i] = 0;
                    end else if (m_tick && m_held[k][i] < L) begin
                        m_held[k][i]++;
                        if (m_held[k][i] == L) m_long[k][i] = 1'b1;
                    end
                    if (s_old == v_old) begin
                        m_dis[k][i] = 0;
                    end else if (m_tick) begin
                        if (m_dis[k][i] + 1 == D) begin
                            m_dis[k][i]   = 0;
                            m_valid[k][i] = s_old;
                            m_press[k][i] = s_old;
                            m_rel[k][i]   = !s_old;
                        end else begin
                            m_dis[k][i]++;
                        end
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = (k == 0) ? pins : pins_al;
            end
            m_tick = (cyc % F == F - 1);
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [4*N:0] act;
        logic [4*N:0] exp;
        for (int k = 0; k < 2; k++) begin
            act = (k == 0) ? {v0, p0, r0, l0, t0} : {v1, p1, r1, l1, t1};
            exp = {m_valid[k], m_press[k], m_rel[k], m_long[k], m_tick};
            check(act == exp, (k == 0) ? "model_dut" : "model_dut_al",
                  longint'(act), longint'(exp));
        end
    end

    int n_press[N]   = '{default: 0};
    int n_release[N] = '{default: 0};
    int n_long[N]    = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (p0[i]) n_press[i]++;
            if (r0[i]) n_release[i]++;
            if (l0[i]) n_long[i]++;
        end
    end

    // sel: 0 valid high, 1 valid low, 2 press, 3 release, 4 long
    task automatic wait_ev(input int sel, input int ch, input int limit,
                           output int at);
        at = -1;
        for (int j = 0; j < limit && at < 0; j++) begin
            @(negedge clk);
            case (sel)
                0: if (v0[ch]) at = cyc - 1;
                1: if (!v0[ch]) at = cyc - 1;
                2: if (p0[ch]) at = cyc - 1;
                3: if (r0[ch]) at = cyc - 1;
                default: if (l0[ch]) at = cyc - 1;
            endcase
        end
    endtask

    task automatic hold_until(input int d0, input int n);
        while (cyc - d0 < n) @(negedge clk);
    endtask

    initial begin
        int first, second, at, pa, la, d0, lat, b;
        pins    = '1;
        pins_al = '1;
        rst     = 1'b1;
        #1 rst  = 1'b0;
        repeat (3) @(negedge clk);
        check({v0, p0, r0, l0, t0} == '0, "reset_hold_outputs",
              longint'({v0, p0, r0, l0, t0}), 0);
        pins = '0;
        @(negedge clk);
        rst = 1'b1;

        first  = -1;
        second = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (t0) begin
                if (first < 0) first = cyc - 1;
                else if (second < 0) second = cyc - 1;
            end
        end
        check(first == 9, "first_tick_edge", first, 9);
        check(second == 19, "second_tick_edge", second, 19);

        b = n_press[0] + n_release[0];
        repeat (5) begin
            pins[0] = 1'b1;
            repeat (20) @(negedge clk);
            pins[0] = 1'b0;
            repeat (20) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check(v0[0] == 1'b0, "bounce_valid", v0[0], 0);
        check(n_press[0] + n_release[0] == b, "bounce_strobes",
              n_press[0] + n_release[0] - b, 0);

        b  = n_press[1];
        d0 = cyc;
        pins[1] = 1'b1;
        wait_ev(0, 1, 60, at);
        lat = at + 1 - d0;
        check(at >= 0 && lat >= 23 && lat <= 33, "press_latency", lat, 23);
        check(p0[1] == 1'b1, "press_same_cycle", p0[1], 1);
        hold_until(d0, 100);
        check(n_press[1] - b == 1, "press_count", n_press[1] - b, 1);

        b  = n_release[1];
        d0 = cyc;
        pins[1] = 1'b0;
        wait_ev(1, 1, 60, at);
        lat = at + 1 - d0;
        check(at >= 0 && lat >= 23 && lat <= 33, "release_latency", lat, 23);
        check(r0[1] == 1'b1, "release_same_cycle", r0[1], 1);
        hold_until(d0, 100);
        check(n_release[1] - b == 1, "release_count", n_release[1] - b, 1);

        b  = n_long[2];
        d0 = cyc;
        pins[2] = 1'b1;
        wait_ev(2, 2, 60, pa);
        wait_ev(4, 2, 70, la);
        check(pa >= 0 && la >= 0 && la - pa == 50, "long_after_press",
              la - pa, 50);
        hold_until(d0, 150);
        pins[2] = 1'b0;
        repeat (60) @(negedge clk);
        check(n_long[2] - b == 1, "long_once", n_long[2] - b, 1);

        check({v1, p1, r1, l1} == '0, "al_idle_outputs",
              longint'({v1, p1, r1, l1}), 0);
        d0 = cyc;
        pins[0] = 1'b1;
        pins[3] = 1'b1;
        pins_al[1] = 1'b0;
        wait_ev(0, 0, 60, at);
        check({v0[0], v0[3], p0[0], p0[3]} == 4'hF, "simul_press",
              longint'({v0[0], v0[3], p0[0], p0[3]}), 15);
        hold_until(d0, 60);
        check(v1 == 4'b0010, "al_press_valid", v1, 2);
        pins[0] = 1'b0;
        pins[3] = 1'b0;
        pins_al[1] = 1'b1;
        repeat (60) @(negedge clk);
        check({v0, v1} == '0, "all_released", longint'({v0, v1}), 0);

        pins[2] = 1'b1;
        wait_ev(2, 2, 60, pa);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check({v0, p0, r0, l0, t0} == '0, "reset_async_clear",
              longint'({v0, p0, r0, l0, t0}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ev(2, 2, 60, pa);
        check(pa == 30, "reset_repress_edge", pa, 30);
        wait_ev(4, 2, 70, la);
        check(pa >= 0 && la >= 0 && la - pa == 50, "reset_long_after_press",
              la - pa, 50);
        pins = '0;
        repeat (60) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/button_deb_multi.md
# button_deb_multi

Parametrised multi-channel successor to the single-button debouncer. Debounces `N_CHAN` asynchronous push-button inputs against one shared millisecond tick. Per channel it produces a stable level plus single-cycle press, release and long-press strobes. Sits between board pins and the control FSMs that need clean, edge-qualified button events.

## Interface
- `CLK_FREQ`, default 95_000: clock frequency in kHz, which is also the tick period in cycles; must be ≥ 2.
- `DEBOUNCE_PER_MS`, default 20: required stable time in ms; must be ≥ 1.
- `LONG_PRESS_MS`, default 1000: held time that fires `button_long`; 0 disables long-press.
- `N_CHAN`, default 4: number of independent channels; must be ≥ 1.
- `ACTIVE_LOW`, default 0: 1 inverts every `button_in` bit, so a pin at 0 means pressed.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset. 0 clears all state immediately; release is synchronous to `clk`.
- `button_in`, input, `N_CHAN`: raw asynchronous button pins.
- `button_valid`, output, `N_CHAN`: debounced level; 1 means pressed.
- `button_press`, output, `N_CHAN`: 1-cycle strobe on a debounced 0→1 change.
- `button_release`, output, `N_CHAN`: 1-cycle strobe on a debounced 1→0 change.
- `button_long`, output, `N_CHAN`: 1-cycle strobe, once per press, when the press is held `LONG_PRESS_MS` ms.
- `tick_ms`, output, 1: shared 1 ms tick, exported for debug and for reuse.

## Operation
- **Prescaler**
  - Counter width is $clog2(CLK_FREQ).
  - Counts 0..CLK_FREQ-1 and wraps to 0.
  - `tick_ms`=1 for exactly the cycle where count==CLK_FREQ-1; it is registered.
- **Synchroniser**
  - Each bit passes two flops, then is XORed with `ACTIVE_LOW`, giving `s[i]`.
  - The synchroniser flops reset to the released level.
- **Debounce counter** (per channel, width $clog2(DEBOUNCE_PER_MS+1))
  - `s[i]` equals `button_valid[i]`: counter is cleared to 0, whatever the tick.
  - Otherwise, on each `tick_ms`: if counter==DEBOUNCE_PER_MS-1, then `button_valid[i]` is set to `s[i]` and the counter cleared; else the counter increments.
- **Acceptance window**
  - A disagreement lasting L cycles is always rejected if L ≤ (DEBOUNCE_PER_MS-1)·CLK_FREQ.
  - It is always accepted if L ≥ DEBOUNCE_PER_MS·CLK_FREQ.
  - In between, acceptance depends on tick phase.
- **Edge strobes**
  - `button_press[i]` / `button_release[i]` are registered together with the `button_valid[i]` update.
  - The strobe is high in the first cycle `button_valid[i]` shows its new value, for exactly 1 cycle.
- **Long-press counter** (per channel, width $clog2(LONG_PRESS_MS+1), saturating)
  - Cleared while `button_valid[i]`=0, and cleared in the cycle `button_valid[i]` rises.
  - While valid=1, increments on each `tick_ms` until it equals LONG_PRESS_MS, then holds.
  - `button_long[i]` pulses in the cycle the counter reaches LONG_PRESS_MS. It cannot fire again until release and a new press.
  - With LONG_PRESS_MS=0 the logic is not generated and `button_long` is tied to 0.
- **Channel independence**
  - Channels share only the prescaler.
  - Simultaneous events on several channels are all reported in the same cycle.

## Timing
- Reset values (rst=0): all outputs 0, prescaler 0, all counters 0, synchroniser flops at the released level.
- Reset asserted mid-debounce or mid-hold aborts the operation. No strobe is emitted during or on exit from reset.
- First `tick_ms` after reset release is at cycle CLK_FREQ-1, counting the first active edge as cycle 0.
- Latency from a clean pin change to the `button_valid` change: 2 synchroniser cycles plus 1 register cycle plus the wait to the DEBOUNCE_PER_MS-th tick.
  - This is between (DEBOUNCE_PER_MS-1)·CLK_FREQ+3 and DEBOUNCE_PER_MS·CLK_FREQ+3 cycles.
- `button_press` and `button_release` never assert in the same cycle on one channel.
- `button_long` never coincides with `button_press` on one channel.
- `button_valid` may change at most once per tick period per channel.

## Test plan
Bench parameters: CLK_FREQ=10, DEBOUNCE_PER_MS=3, LONG_PRESS_MS=5, N_CHAN=4, ACTIVE_LOW=0.
- **Reset:** hold rst=0 with `button_in`=4'hF → all outputs stay 0. After release, the first `tick_ms` is at cycle 9, then every 10 cycles.
- **Bounce rejection:** on ch0, apply 20-cycle high / 20-cycle low glitches, repeated 5 times → `button_valid[0]` stays 0 and no strobes fire.
- **Clean press:** ch1 held high for 100 cycles → `button_valid[1]` rises 23–33 cycles after the edge, with a single `button_press[1]` strobe in that same cycle.
  - Low again for 100 cycles → one `button_release[1]` strobe, with the same latency.
- **Long press:** ch2 held high for 150 cycles → exactly one `button_long[2]` strobe, 50 cycles (5 ticks) after `button_press[2]`. No further strobe occurs until release and a new press.
- **Simultaneous channels and polarity:** ch0 and ch3 rise on the same cycle → both `button_valid` bits and both press strobes in the same cycle.
  - Rerun with ACTIVE_LOW=1: `button_in`=4'hF is idle and all outputs remain 0.
- **Async reset mid-hold:** pull rst low 2 ticks into a long press → all outputs are 0 at once. After release with the pin still high, a new `button_press` follows after a full debounce window, and `button_long` follows 5 ticks after that press.
